// File: rtl/axis_tg_pkg.sv
// Shared types, LFSR step and destination fold helpers for the traffic generator.
package axis_tg_pkg;

   typedef enum logic [1:0] {
      PAT_UNIFORM    = 2'd0,
      PAT_TRANSPOSE  = 2'd1,
      PAT_COMPLEMENT = 2'd2,
      PAT_HOTSPOT    = 2'd3
   } pattern_e;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WAIT_INJ = 2'd1,
      ST_SEND     = 2'd2,
      ST_DONE     = 2'd3
   } tg_state_e;

   localparam logic [31:0] LFSR_POLY    = 32'h8020_0003;
   localparam logic [31:0] DST_SEED_XOR = 32'h5A5A_5A5A;

   // One step of the right-shifting Galois LFSR.
   function automatic logic [31:0] lfsr_next(input logic [31:0] s);
      return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
   endfunction

   // An all-zero LFSR would lock up, so a zero seed becomes 1.
   function automatic logic [31:0] seed_fix(input logic [31:0] s);
      return (s == 32'd0) ? 32'd1 : s;
   endfunction

   // Single subtraction is enough because x < 2*n whenever n > 2^(W-1).
   function automatic int unsigned fold_dest(input int unsigned x, input int unsigned n);
      return (x >= n) ? x - n : x;
   endfunction

endpackage

// File: rtl/axis_tg_dest_sel.sv
// Destination selection: pattern mapping, hotspot steering and self-avoidance.
module axis_tg_dest_sel
   import axis_tg_pkg::*;
#(
   parameter int unsigned TID          = 0,
   parameter int unsigned TDEST_WIDTH  = 4,
   parameter int unsigned NUM_ROUTERS  = 16,
   parameter int unsigned HOTSPOT_DEST = 0,
   parameter bit          ALLOW_SELF   = 1'b1
) (
   input  logic [1:0]             pattern,
   input  logic [TDEST_WIDTH-1:0] dst_rand,
   input  logic [15:0]            hot_rand,
   input  logic [15:0]            hotspot_load,
   output logic [TDEST_WIDTH-1:0] dest_c
);

   localparam int unsigned HALF = TDEST_WIDTH / 2;
   localparam logic [TDEST_WIDTH-1:0] TID_W = TDEST_WIDTH'(TID);
   localparam logic [TDEST_WIDTH-1:0] TRN_W = {TID_W[HALF-1:0], TID_W[TDEST_WIDTH-1:HALF]};
   localparam logic [TDEST_WIDTH-1:0] CMP_W = ~TID_W;
   localparam int unsigned SELF_NEXT = ((TID + 1) == NUM_ROUTERS) ? 0 : TID + 1;

   pattern_e    pat;
   int unsigned uni;
   int unsigned sel;

   assign pat = pattern_e'(pattern);

   // Map the requested pattern to a destination index in [0, NUM_ROUTERS).
   always_comb begin
      uni = fold_dest(32'(dst_rand), NUM_ROUTERS);
      sel = uni;
      case (pat)
         PAT_UNIFORM:    sel = uni;
         PAT_TRANSPOSE:  sel = fold_dest(32'(TRN_W), NUM_ROUTERS);
         PAT_COMPLEMENT: sel = fold_dest(32'(CMP_W), NUM_ROUTERS);
         PAT_HOTSPOT:    sel = (hot_rand < hotspot_load) ? HOTSPOT_DEST : uni;
      endcase
      // Only the random patterns avoid self; deterministic ones may self-target.
      if (!ALLOW_SELF && (pat == PAT_UNIFORM || pat == PAT_HOTSPOT) && sel == TID)
         sel = fold_dest(SELF_NEXT, NUM_ROUTERS);
      dest_c = TDEST_WIDTH'(sel);
   end

endmodule

// File: rtl/axis_tg_pattern.sv
// AXI-Stream traffic generator with destination patterns, multi-flit packets,
// per-destination sequence numbers and pause/resume.
module axis_tg_pattern
   import axis_tg_pkg::*;
#(
   parameter logic [31:0] SEED          = 32'd1,
   parameter int unsigned TID           = 0,
   parameter int unsigned TDATA_WIDTH   = 64,
   parameter int unsigned TDEST_WIDTH   = 4,
   parameter int unsigned TID_WIDTH     = 4,
   parameter int unsigned NUM_ROUTERS   = 16,
   parameter int unsigned COUNT_WIDTH   = 32,
   parameter int unsigned MAX_PKT_FLITS = 4,
   parameter int unsigned HOTSPOT_DEST  = 0,
   parameter bit          ALLOW_SELF    = 1'b1
) (
   input  logic                                        clk,
   input  logic                                        rst,
   input  logic                                        start,
   input  logic [15:0]                                 load,
   input  logic [15:0]                                 hotspot_load,
   input  logic [1:0]                                  pattern,
   input  logic [$clog2(MAX_PKT_FLITS+1)-1:0]          pkt_len,
   input  logic [COUNT_WIDTH-1:0]                      num_packets,
   input  logic [TDATA_WIDTH/2-1:0]                    ticks,
   output logic                                        done,
   output logic                                        busy,
   output logic [NUM_ROUTERS-1:0][COUNT_WIDTH-1:0]     sent_packets,
   output logic [COUNT_WIDTH-1:0]                      total_sent_packets,
   output logic                                        axis_out_tvalid,
   input  logic                                        axis_out_tready,
   output logic [TDATA_WIDTH-1:0]                      axis_out_tdata,
   output logic                                        axis_out_tlast,
   output logic [TID_WIDTH-1:0]                        axis_out_tid,
   output logic [TDEST_WIDTH-1:0]                      axis_out_tdest
);

   localparam int unsigned LEN_W  = $clog2(MAX_PKT_FLITS + 1);
   localparam int unsigned HALF_W = TDATA_WIDTH / 2;
   localparam logic [31:0] INJ_SEED = seed_fix(SEED);
   localparam logic [31:0] DST_SEED = seed_fix(SEED ^ DST_SEED_XOR);

   tg_state_e                               state_q, state_d;
   logic [31:0]                             inj_lfsr_q, inj_lfsr_d;
   logic [31:0]                             dst_lfsr_q, dst_lfsr_d;
   logic [TDEST_WIDTH-1:0]                  dest_q, dest_d;
   logic [LEN_W-1:0]                        len_q, len_d;
   logic [LEN_W-1:0]                        flit_q, flit_d;
   logic                                    tvalid_q, tvalid_d;
   logic                                    tlast_q, tlast_d;
   logic [TDATA_WIDTH-1:0]                  tdata_q, tdata_d;
   logic                                    done_q, done_d;
   logic                                    busy_q, busy_d;
   logic [NUM_ROUTERS-1:0][COUNT_WIDTH-1:0] sent_q, sent_d;
   logic [COUNT_WIDTH-1:0]                  total_q, total_d;

   logic [TDEST_WIDTH-1:0]                  dest_c;
   logic [LEN_W-1:0]                        len_clamp;
   logic [COUNT_WIDTH-1:0]                  seq_sel;
   logic                                    hs;

   axis_tg_dest_sel #(
      .TID          (TID),
      .TDEST_WIDTH  (TDEST_WIDTH),
      .NUM_ROUTERS  (NUM_ROUTERS),
      .HOTSPOT_DEST (HOTSPOT_DEST),
      .ALLOW_SELF   (ALLOW_SELF)
   ) u_dest_sel (
      .pattern      (pattern),
      .dst_rand     (dst_lfsr_q[TDEST_WIDTH-1:0]),
      .hot_rand     (dst_lfsr_q[31:16]),
      .hotspot_load (hotspot_load),
      .dest_c       (dest_c)
   );

   assign hs = tvalid_q & axis_out_tready;

   // Next-state, datapath and counter updates for the generator FSM.
   always_comb begin
      state_d    = state_q;
      inj_lfsr_d = lfsr_next(inj_lfsr_q);
      dst_lfsr_d = lfsr_next(dst_lfsr_q);
      dest_d     = dest_q;
      len_d      = len_q;
      flit_d     = flit_q;
      tvalid_d   = tvalid_q;
      tlast_d    = tlast_q;
      tdata_d    = tdata_q;
      sent_d     = sent_q;
      total_d    = total_q;

      // Zero-length requests become single flits; oversize ones are capped.
      if (pkt_len == '0)
         len_clamp = LEN_W'(1);
      else if (32'(pkt_len) > MAX_PKT_FLITS)
         len_clamp = LEN_W'(MAX_PKT_FLITS);
      else
         len_clamp = pkt_len;

      seq_sel = '0;
      for (int unsigned i = 0; i < NUM_ROUTERS; i++)
         if (dest_c == TDEST_WIDTH'(i))
            seq_sel = sent_q[i];

      case (state_q)
         ST_IDLE: begin
            if (start)
               state_d = (total_q >= num_packets) ? ST_DONE : ST_WAIT_INJ;
         end
         ST_WAIT_INJ: begin
            if (!start) begin
               state_d = ST_IDLE;
            end else if (inj_lfsr_q[15:0] < load) begin
               state_d  = ST_SEND;
               dest_d   = dest_c;
               len_d    = len_clamp;
               flit_d   = '0;
               tvalid_d = 1'b1;
               tlast_d  = (len_clamp == LEN_W'(1));
               tdata_d  = {ticks, HALF_W'(seq_sel)};
            end
         end
         ST_SEND: begin
            if (hs) begin
               if (tlast_q) begin
                  tvalid_d = 1'b0;
                  tlast_d  = 1'b0;
                  total_d  = total_q + COUNT_WIDTH'(1);
                  for (int unsigned i = 0; i < NUM_ROUTERS; i++)
                     if (dest_q == TDEST_WIDTH'(i))
                        sent_d[i] = sent_q[i] + COUNT_WIDTH'(1);
                  state_d  = (total_d == num_packets) ? ST_DONE : ST_WAIT_INJ;
               end else begin
                  flit_d  = flit_q + LEN_W'(1);
                  tlast_d = ((flit_q + LEN_W'(2)) == len_q);
               end
            end
         end
         ST_DONE: begin
            state_d = ST_DONE;
         end
      endcase

      busy_d = (state_d == ST_SEND);
      done_d = (state_d == ST_DONE);
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         inj_lfsr_q <= INJ_SEED;
         dst_lfsr_q <= DST_SEED;
         dest_q     <= '0;
         len_q      <= '0;
         flit_q     <= '0;
         tvalid_q   <= 1'b0;
         tlast_q    <= 1'b0;
         tdata_q    <= '0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
         sent_q     <= '0;
         total_q    <= '0;
      end else begin
         state_q    <= state_d;
         inj_lfsr_q <= inj_lfsr_d;
         dst_lfsr_q <= dst_lfsr_d;
         dest_q     <= dest_d;
         len_q      <= len_d;
         flit_q     <= flit_d;
         tvalid_q   <= tvalid_d;
         tlast_q    <= tlast_d;
         tdata_q    <= tdata_d;
         done_q     <= done_d;
         busy_q     <= busy_d;
         sent_q     <= sent_d;
         total_q    <= total_d;
      end
   end

   assign done               = done_q;
   assign busy               = busy_q;
   assign sent_packets       = sent_q;
   assign total_sent_packets = total_q;
   assign axis_out_tvalid    = tvalid_q;
   assign axis_out_tdata     = tdata_q;
   assign axis_out_tlast     = tlast_q;
   assign axis_out_tid       = TID_WIDTH'(TID);
   assign axis_out_tdest     = dest_q;

endmodule

// File: tb/tb_axis_tg_pattern.sv
// Bench for axis_tg_pattern: table-driven packet runs plus directed corner cases.
module tb_axis_tg_pattern;

   logic              clk;
   logic              rst;
   logic              start;
   logic [15:0]       load;
   logic [15:0]       hotspot_load;
   logic [1:0]        pattern;
   logic [2:0]        pkt_len;
   logic [31:0]       num_packets;
   logic [31:0]       ticks;
   logic              done;
   logic              busy;
   logic [15:0][31:0] sent_packets;
   logic [31:0]       total_sent_packets;
   logic              tvalid;
   logic              tready;
   logic [63:0]       tdata;
   logic              tlast;
   logic [3:0]        tid;
   logic [3:0]        tdest;

   axis_tg_pattern #(
      .SEED         (32'd1),
      .TID          (6),
      .TDATA_WIDTH  (64),
      .TDEST_WIDTH  (4),
      .TID_WIDTH    (4),
      .NUM_ROUTERS  (16),
      .COUNT_WIDTH  (32),
      .MAX_PKT_FLITS(4),
      .HOTSPOT_DEST (3),
      .ALLOW_SELF   (1'b0)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .start             (start),
      .load              (load),
      .hotspot_load      (hotspot_load),
      .pattern           (pattern),
      .pkt_len           (pkt_len),
      .num_packets       (num_packets),
      .ticks             (ticks),
      .done              (done),
      .busy              (busy),
      .sent_packets      (sent_packets),
      .total_sent_packets(total_sent_packets),
      .axis_out_tvalid   (tvalid),
      .axis_out_tready   (tready),
      .axis_out_tdata    (tdata),
      .axis_out_tlast    (tlast),
      .axis_out_tid      (tid),
      .axis_out_tdest    (tdest)
   );

   int checks = 0;
   int errors = 0;

   // Monitor model state
   int          seq_model [16];
   int          pkt_flit;
   logic [31:0] pkt_ts;
   bit          prev_stall, prev_valid, prev_last;
   logic [63:0] prev_data;
   logic [3:0]  prev_dest;
   int          mon_flits, mon_pkts;
   int          exp_dest, exp_len;
   bit          rand_ready;

   typedef struct {
      logic [1:0]  pat;
      logic [2:0]  len;
      int unsigned num;
      logic [15:0] ld;
      bit          rnd;
      int          exp_dest;
      int          exp_len;
   } vec_t;

   vec_t tbl [7];

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic longint sent_sum();
      longint s = 0;
      for (int i = 0; i < 16; i++) s += longint'(sent_packets[i]);
      return s;
   endfunction

   task automatic do_reset();
      step();
      rst   = 1'b1;
      start = 1'b0;
      step();
      rst   = 1'b0;
   endtask

   task automatic wait_done(input int max_cyc, input string name);
      int n = 0;
      while (!done && n < max_cyc) begin
         step();
         n++;
      end
      chk({name, "_done_timeout"}, done, 1);
   endtask

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Free-running timestamp and optional random backpressure.
   initial begin
      ticks = 32'd0;
      forever begin
         @(posedge clk);
         #1;
         ticks = ticks + 32'd1;
         if (rand_ready) tready = 1'($urandom_range(0, 1));
      end
   end

   // Stream monitor: stability, timestamps, sequence numbers, tlast framing.
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            for (int i = 0; i < 16; i++) seq_model[i] = 0;
            pkt_flit   = 0;
            prev_stall = 1'b0;
            prev_valid = 1'b0;
            prev_last  = 1'b0;
            mon_flits  = 0;
            mon_pkts   = 0;
         end else begin
            if (prev_stall) begin
               chk("stall_tvalid", tvalid, 1);
               chk("stall_tdata", tdata, prev_data);
               chk("stall_tdest", tdest, prev_dest);
               chk("stall_tlast", tlast, prev_last);
            end
            if (tvalid && !prev_valid)
               chk("ts_at_rise", tdata[63:32], ticks - 32'd1);
            if (done)
               chk("valid_after_done", tvalid, 0);
            if (tvalid && tready) begin
               mon_flits++;
               chk("tid", tid, 6);
               if (exp_dest >= 0) chk("tdest", tdest, exp_dest);
               if (pkt_flit == 0) begin
                  pkt_ts = tdata[63:32];
                  chk("seq", tdata[31:0], seq_model[tdest]);
               end else begin
                  chk("ts_in_pkt", tdata[63:32], pkt_ts);
               end
               chk("tlast", tlast, (pkt_flit == exp_len - 1) ? 1 : 0);
               if (pkt_flit == exp_len - 1) begin
                  seq_model[tdest]++;
                  mon_pkts++;
                  pkt_flit = 0;
               end else begin
                  pkt_flit++;
               end
            end
            prev_stall = tvalid && !tready;
            prev_valid = tvalid;
            prev_last  = tlast;
            prev_data  = tdata;
            prev_dest  = tdest;
         end
      end
   end

   initial begin
      int n;
      int cnt;
      string nm;

      //          pat   len   num  load      rnd   dest len
      tbl[0] = '{2'd0, 3'd1, 100, 16'hFFFF, 1'b0, -1, 1};
      tbl[1] = '{2'd1, 3'd3, 10,  16'hFFFF, 1'b0,  9, 3};
      tbl[2] = '{2'd2, 3'd2, 12,  16'hFFFF, 1'b0,  9, 2};
      tbl[3] = '{2'd0, 3'd4, 30,  16'hFFFF, 1'b1, -1, 4};
      tbl[4] = '{2'd0, 3'd0, 20,  16'hFFFF, 1'b0, -1, 1};
      tbl[5] = '{2'd1, 3'd7, 5,   16'hFFFF, 1'b1,  9, 4};
      tbl[6] = '{2'd0, 3'd2, 40,  16'h4000, 1'b0, -1, 2};

      rst          = 1'b1;
      start        = 1'b0;
      load         = 16'hFFFF;
      hotspot_load = 16'h0000;
      pattern      = 2'd0;
      pkt_len      = 3'd1;
      num_packets  = 32'd0;
      tready       = 1'b1;
      rand_ready   = 1'b0;
      exp_dest     = -1;
      exp_len      = 1;

      // Reset state
      do_reset();
      chk("rst_tvalid", tvalid, 0);
      chk("rst_tlast", tlast, 0);
      chk("rst_tdata", tdata, 0);
      chk("rst_tdest", tdest, 0);
      chk("rst_done", done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_total", total_sent_packets, 0);
      chk("rst_sent_sum", sent_sum(), 0);

      // Table-driven packet runs
      for (int r = 0; r < 7; r++) begin
         do_reset();
         pattern     = tbl[r].pat;
         pkt_len     = tbl[r].len;
         num_packets = tbl[r].num;
         load        = tbl[r].ld;
         exp_dest    = tbl[r].exp_dest;
         exp_len     = tbl[r].exp_len;
         tready      = 1'b1;
         start       = 1'b1;
         rand_ready  = tbl[r].rnd;
         nm = $sformatf("run%0d", r);
         wait_done(20000, nm);
         repeat (5) step();
         rand_ready = 1'b0;
         tready     = 1'b1;
         chk({nm, "_total"}, total_sent_packets, tbl[r].num);
         chk({nm, "_sent_sum"}, sent_sum(), tbl[r].num);
         chk({nm, "_mon_pkts"}, mon_pkts, tbl[r].num);
         chk({nm, "_mon_flits"}, mon_flits, tbl[r].num * tbl[r].exp_len);
         chk({nm, "_busy"}, busy, 0);
         chk({nm, "_tvalid"}, tvalid, 0);
         chk({nm, "_sent_self"}, sent_packets[6], 0);
         if (tbl[r].exp_dest >= 0)
            chk({nm, "_sent_dest"}, sent_packets[tbl[r].exp_dest], tbl[r].num);
      end

      // num_packets = 0: done one cycle after start, no traffic
      do_reset();
      pattern = 2'd0; pkt_len = 3'd1; load = 16'hFFFF; exp_dest = -1; exp_len = 1;
      num_packets = 32'd0;
      start = 1'b1;
      chk("np0_done_before", done, 0);
      step();
      chk("np0_done_after1", done, 1);
      chk("np0_tvalid", tvalid, 0);

      // load = 0: never injects
      do_reset();
      load = 16'h0000; num_packets = 32'd10;
      start = 1'b1;
      cnt = 0;
      repeat (1000) begin
         step();
         if (tvalid) cnt++;
      end
      chk("load0_valid_cycles", cnt, 0);
      chk("load0_total", total_sent_packets, 0);
      chk("load0_busy", busy, 0);
      load = 16'hFFFF;

      // Pause in WAIT_INJ after 20 packets, then resume to 60
      do_reset();
      pkt_len = 3'd1; exp_len = 1; num_packets = 32'd60;
      start = 1'b1;
      n = 0;
      while (total_sent_packets != 32'd20 && n < 2000) begin
         step();
         n++;
      end
      chk("pause_reach20", total_sent_packets, 20);
      start = 1'b0;
      cnt = 0;
      repeat (50) begin
         step();
         if (tvalid) cnt++;
      end
      chk("pause_valid_cycles", cnt, 0);
      chk("pause_total_held", total_sent_packets, 20);
      chk("pause_busy", busy, 0);
      start = 1'b1;
      wait_done(2000, "resume");
      chk("resume_total", total_sent_packets, 60);
      chk("resume_mon_pkts", mon_pkts, 60);

      // Deassert start mid-packet: packet still completes
      do_reset();
      pkt_len = 3'd4; exp_len = 4; num_packets = 32'd10;
      start = 1'b1;
      n = 0;
      while (!tvalid && n < 100) begin
         step();
         n++;
      end
      chk("midpkt_tvalid_seen", tvalid, 1);
      start = 1'b0;
      repeat (12) step();
      chk("midpkt_total", total_sent_packets, 1);
      chk("midpkt_mon_pkts", mon_pkts, 1);
      chk("midpkt_mon_flits", mon_flits, 4);
      chk("midpkt_tvalid_after", tvalid, 0);
      chk("midpkt_busy", busy, 0);

      // Reset asserted while a packet is stalled mid-flight
      do_reset();
      pkt_len = 3'd4; exp_len = 4; num_packets = 32'd10;
      start = 1'b1;
      n = 0;
      while (total_sent_packets < 32'd2 && n < 200) begin
         step();
         n++;
      end
      chk("rstmid_two_pkts", total_sent_packets, 2);
      tready = 1'b0;
      n = 0;
      while (!tvalid && n < 100) begin
         step();
         n++;
      end
      step();
      step();
      chk("rstmid_stalled_valid", tvalid, 1);
      rst = 1'b1;
      step();
      chk("rstmid_tvalid", tvalid, 0);
      chk("rstmid_total", total_sent_packets, 0);
      chk("rstmid_sent_sum", sent_sum(), 0);
      chk("rstmid_busy", busy, 0);
      chk("rstmid_done", done, 0);
      rst = 1'b0;
      start = 1'b0;
      tready = 1'b1;

      // Hotspot with self-avoidance
      do_reset();
      pattern = 2'd3; hotspot_load = 16'h8000; pkt_len = 3'd1; exp_len = 1;
      exp_dest = -1; num_packets = 32'd4096; load = 16'hFFFF;
      start = 1'b1;
      wait_done(20000, "hotspot");
      chk("hotspot_total", total_sent_packets, 4096);
      chk("hotspot_self", sent_packets[6], 0);
      chk("hotspot_dest3_range",
          (sent_packets[3] >= 32'd1946 && sent_packets[3] <= 32'd2400) ? 1 : 0, 1);
      if (!(sent_packets[3] >= 32'd1946 && sent_packets[3] <= 32'd2400))
         $display("  hotspot dest3 count %0d", sent_packets[3]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
